// File: rtl/video_scan_generator.sv
// Raster video generator: H/V timing counters, scaled framebuffer addressing,
// a latency-matched pipe for colour/sync/strobes, and a frame-gated enable.
module video_scan_generator #(
    parameter int   H_ACTIVE    = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic HSYNC_POL   = 1'b0,
    parameter logic VSYNC_POL   = 1'b0,
    parameter int   SCALE_LOG2  = 2,
    parameter int   MEM_LATENCY = 1,
    parameter int   ADDR_W      = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic [ADDR_W-1:0] addr,
    input  logic [11:0]       data,
    output logic [11:0]       video_rgb,
    output logic              video_hsync,
    output logic              video_vsync,
    output logic              frame_start,
    output logic              line_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);
    localparam int LINE_W  = H_ACTIVE >> SCALE_LOG2;
    // Stages between the counters and the output register: addr + memory.
    localparam int PIPE_D  = MEM_LATENCY + 1;

    localparam logic [HC_W-1:0]   H_ZERO     = HC_W'(0);
    localparam logic [HC_W-1:0]   H_ONE      = HC_W'(1);
    localparam logic [HC_W-1:0]   H_LAST     = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0]   H_ACT_END  = HC_W'(H_ACTIVE);
    localparam logic [HC_W-1:0]   H_SYNC_BEG = HC_W'(H_ACTIVE + H_FP);
    localparam logic [HC_W-1:0]   H_SYNC_END = HC_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VC_W-1:0]   V_ZERO     = VC_W'(0);
    localparam logic [VC_W-1:0]   V_ONE      = VC_W'(1);
    localparam logic [VC_W-1:0]   V_LAST     = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0]   V_ACT_END  = VC_W'(V_ACTIVE);
    localparam logic [VC_W-1:0]   V_SYNC_BEG = VC_W'(V_ACTIVE + V_FP);
    localparam logic [VC_W-1:0]   V_SYNC_END = VC_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VC_W-1:0]   SUB_MASK   = VC_W'((1 << SCALE_LOG2) - 1);
    localparam logic [ADDR_W-1:0] A_ZERO     = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] LINE_STEP  = ADDR_W'(LINE_W);

    logic [HC_W-1:0]   hcnt_q, hcnt_d;
    logic [VC_W-1:0]   vcnt_q, vcnt_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              en_frame_q, en_frame_d;
    logic [PIPE_D-1:0] vis_pipe_q, vis_pipe_d;
    logic [PIPE_D-1:0] hs_pipe_q, hs_pipe_d;
    logic [PIPE_D-1:0] vs_pipe_q, vs_pipe_d;
    logic [PIPE_D-1:0] fs_pipe_q, fs_pipe_d;
    logic [PIPE_D-1:0] ls_pipe_q, ls_pipe_d;
    logic [11:0]       rgb_q, rgb_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    logic              fs_q, fs_d;
    logic              ls_q, ls_d;

    logic              h_wrap_s;
    logic              v_wrap_s;
    logic [VC_W-1:0]   vcnt_nxt_s;
    logic              active_s;
    logic              hs_s;
    logic              vs_s;
    logic              fs_s;
    logic              ls_s;
    logic              en_eff_s;
    logic [ADDR_W-1:0] nxt_line_base_s;

    // Next-state logic for counters, addressing, enable latch and output pipe.
    always_comb begin
        h_wrap_s   = (hcnt_q == H_LAST);
        v_wrap_s   = (vcnt_q == V_LAST);
        vcnt_nxt_s = v_wrap_s ? V_ZERO : (vcnt_q + V_ONE);
        hcnt_d     = h_wrap_s ? H_ZERO : (hcnt_q + H_ONE);
        vcnt_d     = h_wrap_s ? vcnt_nxt_s : vcnt_q;

        active_s = (hcnt_q < H_ACT_END) && (vcnt_q < V_ACT_END);
        hs_s     = (hcnt_q >= H_SYNC_BEG) && (hcnt_q < H_SYNC_END);
        vs_s     = (vcnt_q >= V_SYNC_BEG) && (vcnt_q < V_SYNC_END);
        fs_s     = (hcnt_q == H_ZERO) && (vcnt_q == V_ZERO);
        ls_s     = (hcnt_q == H_ZERO) && (vcnt_q < V_ACT_END);

        // Base of the line that holds the next active pixel; a new framebuffer
        // row starts only every 2^SCALE_LOG2 lines.
        if ((vcnt_nxt_s >= V_ACT_END) || (vcnt_nxt_s == V_ZERO)) begin
            nxt_line_base_s = A_ZERO;
        end else if ((vcnt_nxt_s & SUB_MASK) == V_ZERO) begin
            nxt_line_base_s = line_base_q + LINE_STEP;
        end else begin
            nxt_line_base_s = line_base_q;
        end
        line_base_d = h_wrap_s ? nxt_line_base_s : line_base_q;
        addr_d      = active_s ? (line_base_q + ADDR_W'(hcnt_q >> SCALE_LOG2))
                               : nxt_line_base_s;

        en_eff_s   = fs_s ? enable : en_frame_q;
        en_frame_d = en_eff_s;

        vis_pipe_d = {vis_pipe_q[PIPE_D-2:0], active_s & en_eff_s};
        hs_pipe_d  = {hs_pipe_q[PIPE_D-2:0], hs_s};
        vs_pipe_d  = {vs_pipe_q[PIPE_D-2:0], vs_s};
        fs_pipe_d  = {fs_pipe_q[PIPE_D-2:0], fs_s};
        ls_pipe_d  = {ls_pipe_q[PIPE_D-2:0], ls_s};

        rgb_d   = vis_pipe_q[PIPE_D-1] ? data : 12'h000;
        hsync_d = hs_pipe_q[PIPE_D-1] ? HSYNC_POL : ~HSYNC_POL;
        vsync_d = vs_pipe_q[PIPE_D-1] ? VSYNC_POL : ~VSYNC_POL;
        fs_d    = fs_pipe_q[PIPE_D-1];
        ls_d    = ls_pipe_q[PIPE_D-1];
    end

    // State registers; reset parks syncs at their inactive level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt_q      <= H_ZERO;
            vcnt_q      <= V_ZERO;
            line_base_q <= A_ZERO;
            addr_q      <= A_ZERO;
            en_frame_q  <= 1'b0;
            vis_pipe_q  <= {PIPE_D{1'b0}};
            hs_pipe_q   <= {PIPE_D{1'b0}};
            vs_pipe_q   <= {PIPE_D{1'b0}};
            fs_pipe_q   <= {PIPE_D{1'b0}};
            ls_pipe_q   <= {PIPE_D{1'b0}};
            rgb_q       <= 12'h000;
            hsync_q     <= ~HSYNC_POL;
            vsync_q     <= ~VSYNC_POL;
            fs_q        <= 1'b0;
            ls_q        <= 1'b0;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            line_base_q <= line_base_d;
            addr_q      <= addr_d;
            en_frame_q  <= en_frame_d;
            vis_pipe_q  <= vis_pipe_d;
            hs_pipe_q   <= hs_pipe_d;
            vs_pipe_q   <= vs_pipe_d;
            fs_pipe_q   <= fs_pipe_d;
            ls_pipe_q   <= ls_pipe_d;
            rgb_q       <= rgb_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            fs_q        <= fs_d;
            ls_q        <= ls_d;
        end
    end

    assign addr        = addr_q;
    assign video_rgb   = rgb_q;
    assign video_hsync = hsync_q;
    assign video_vsync = vsync_q;
    assign frame_start = fs_q;
    assign line_start  = ls_q;

endmodule
